// File: rtl/neg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : neg_arbiter_if
// Description : Request/grant/result bundle between two requesters and the
//               shared negation arbiter. The master side is the requester
//               pair, the slave side is neg_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface neg_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] a0;
  logic [7:0] a1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] result;
  logic       c_out;
  logic       ovf;
  logic       busy;

  modport master (
    output req0, req1, a0, a1,
    input  gnt0, gnt1, done0, done1, result, c_out, ovf, busy
  );

  modport slave (
    input  req0, req1, a0, a1,
    output gnt0, gnt1, done0, done1, result, c_out, ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/neg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : neg_arbiter (with helper neg_unit)
// Description : Two-requester arbiter in front of a single 8-bit two's
//               complement negation unit. A request is captured at an
//               arbitration point (IDLE or DONE), granted during EXEC and
//               reported with a done pulse during DONE, giving one operation
//               every two cycles when requests are back to back.
//               Compile-time option NEG_ARB_RR_EN selects round-robin tie
//               breaking; without it requester 0 always wins a tie.
// Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// neg_unit : combinational y = -a, with the carry out of (~a + 1).
// The carry is set only when a is zero (~a = 8'hFF wraps on the increment).
// ----------------------------------------------------------------------------
module neg_unit (
  input  wire logic [7:0] a_i,
  output logic      [7:0] y_o,
  output logic            c_o
);
  logic [8:0] w_sum;

  // Invert-and-increment with the ninth bit kept as carry out
  always_comb begin
    w_sum = {1'b0, ~a_i} + 9'd1;
    y_o   = w_sum[7:0];
    c_o   = w_sum[8];
  end
endmodule

// ----------------------------------------------------------------------------
// neg_arbiter
// ----------------------------------------------------------------------------
module neg_arbiter (
  input  wire logic     clk,
  input  wire logic     rst_n,
  neg_arbiter_if.slave  arb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic       owner_q, owner_d;
  logic [7:0] result_q, result_d;
  logic       c_out_q, c_out_d;
  logic       ovf_q, ovf_d;
`ifdef NEG_ARB_RR_EN
  // Index of the most recent winner; the other requester wins the next tie.
  logic       last_q, last_d;
`endif

  logic       w_any_req;
  logic       w_winner;
  logic [7:0] w_neg_y;
  logic       w_neg_c;

  // Single shared negator, always fed from the captured operand
  neg_unit u_neg (
    .a_i (op_q),
    .y_o (w_neg_y),
    .c_o (w_neg_c)
  );

  // Pick the requester to serve if an arbitration point is reached now
  always_comb begin
    w_any_req = arb.req0 | arb.req1;
`ifdef NEG_ARB_RR_EN
    if (arb.req0 && arb.req1) begin
      w_winner = ~last_q;
    end else begin
      w_winner = arb.req1;
    end
`else
    // Requester 1 wins only when requester 0 is not asking
    w_winner = ~arb.req0;
`endif
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 8'h00;
      owner_q  <= 1'b0;
      result_q <= 8'h00;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef NEG_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
`ifdef NEG_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  // Next-state logic: capture at IDLE/DONE, compute-and-latch at EXEC
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    owner_d  = owner_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
`ifdef NEG_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_any_req) begin
          op_d    = w_winner ? arb.a1 : arb.a0;
          owner_d = w_winner;
`ifdef NEG_ARB_RR_EN
          last_d  = w_winner;
`endif
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        // Requests are ignored here; the result is latched for DONE
        result_d = w_neg_y;
        c_out_d  = w_neg_c;
        ovf_d    = (op_q == 8'h80);
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant/done pulses decoded from state and owner so they can never overlap
  always_comb begin
    arb.gnt0  = 1'b0;
    arb.gnt1  = 1'b0;
    arb.done0 = 1'b0;
    arb.done1 = 1'b0;
    if (state_q == S_EXEC) begin
      arb.gnt0 = ~owner_q;
      arb.gnt1 = owner_q;
    end
    if (state_q == S_DONE) begin
      arb.done0 = ~owner_q;
      arb.done1 = owner_q;
    end
  end

  assign arb.busy   = (state_q == S_EXEC) || (state_q == S_DONE);
  assign arb.result = result_q;
  assign arb.c_out  = c_out_q;
  assign arb.ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_neg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_neg_arbiter
// Description : Directed self-checking bench for neg_arbiter. Expected values
//               are hand-computed negations. Honours NEG_ARB_RR_EN for the
//               continuous-request grant order.
// Revision    : 1.0  initial release
// ============================================================================
module tb_neg_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  neg_arbiter_if bus ();

  neg_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation started from IDLE: gnt, done with result, back to IDLE
  task automatic op(input bit who, input logic [7:0] opnd, input logic [7:0] exp_r,
                    input bit exp_c, input bit exp_v, input string tag);
    if (who) begin
      bus.req1 = 1'b1;
      bus.a1   = opnd;
    end else begin
      bus.req0 = 1'b1;
      bus.a0   = opnd;
    end
    step;
    chk({tag, ".gnt"}, {bus.gnt1, bus.gnt0}, who ? 2'b10 : 2'b01);
    chk({tag, ".busy_exec"}, bus.busy, 1'b1);
    chk({tag, ".done_exec"}, {bus.done1, bus.done0}, 2'b00);
    if (who) bus.req1 = 1'b0;
    else     bus.req0 = 1'b0;
    step;
    chk({tag, ".done"}, {bus.done1, bus.done0}, who ? 2'b10 : 2'b01);
    chk({tag, ".gnt_done"}, {bus.gnt1, bus.gnt0}, 2'b00);
    chk({tag, ".result"}, bus.result, exp_r);
    chk({tag, ".c_out"}, bus.c_out, exp_c);
    chk({tag, ".ovf"}, bus.ovf, exp_v);
    step;
    chk({tag, ".busy_idle"}, bus.busy, 1'b0);
    chk({tag, ".done_idle"}, {bus.done1, bus.done0}, 2'b00);
    chk({tag, ".hold"}, bus.result, exp_r);
  endtask

  initial begin
    bit exp_own;
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = 8'h00;
    bus.a1   = 8'h00;

    // Reset state
    #1;
    chk("rst.result", bus.result, 8'h00);
    chk("rst.flags", {bus.busy, bus.c_out, bus.ovf}, 3'b000);
    chk("rst.gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("rst.done", {bus.done1, bus.done0}, 2'b00);
    step;
    step;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operations and corner operands
    op(1'b0, 8'h05, 8'hFB, 1'b0, 1'b0, "op_05");
    op(1'b0, 8'h80, 8'h80, 1'b0, 1'b1, "op_80");
    op(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, "op_00");
    op(1'b1, 8'h7F, 8'h81, 1'b0, 1'b0, "op_7f");

    // A request raised and dropped between edges has no effect
    #2;
    bus.req0 = 1'b1;
    bus.a0   = 8'h33;
    #3;
    bus.req0 = 1'b0;
    step;
    chk("withdraw.busy", bus.busy, 1'b0);
    chk("withdraw.gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("withdraw.result", bus.result, 8'h81);

    // Both requests held continuously; last winner so far was requester 1
    bus.req0 = 1'b1;
    bus.a0   = 8'h01;
    bus.req1 = 1'b1;
    bus.a1   = 8'h02;
    for (int k = 0; k < 4; k++) begin
`ifdef NEG_ARB_RR_EN
      exp_own = k[0];
`else
      exp_own = 1'b0;
`endif
      step;
      chk("cont.gnt", {bus.gnt1, bus.gnt0}, exp_own ? 2'b10 : 2'b01);
      if (k == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      step;
      chk("cont.done", {bus.done1, bus.done0}, exp_own ? 2'b10 : 2'b01);
      chk("cont.result", bus.result, exp_own ? 8'hFE : 8'hFF);
    end
    step;
    chk("cont.idle", bus.busy, 1'b0);

    // Simultaneous rise: requester 0 first, requester 1 kept pending
    bus.req0 = 1'b1;
    bus.a0   = 8'h01;
    bus.req1 = 1'b1;
    bus.a1   = 8'h7F;
    step;
    chk("tie.gnt0", {bus.gnt1, bus.gnt0}, 2'b01);
    bus.req0 = 1'b0;
    step;
    chk("tie.done0", {bus.done1, bus.done0}, 2'b01);
    chk("tie.gnt_d0", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("tie.result0", bus.result, 8'hFF);
    step;
    chk("tie.gnt1", {bus.gnt1, bus.gnt0}, 2'b10);
    chk("tie.done_g1", {bus.done1, bus.done0}, 2'b00);
    bus.req1 = 1'b0;
    step;
    chk("tie.done1", {bus.done1, bus.done0}, 2'b10);
    chk("tie.result1", bus.result, 8'h81);
    step;
    chk("tie.idle", bus.busy, 1'b0);

    // Reset during EXEC aborts the operation
    bus.req1 = 1'b1;
    bus.a1   = 8'h10;
    step;
    chk("abort.gnt1", {bus.gnt1, bus.gnt0}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("abort.done", {bus.done1, bus.done0}, 2'b00);
    chk("abort.result", bus.result, 8'h00);
    chk("abort.flags", {bus.busy, bus.c_out, bus.ovf}, 3'b000);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1;
    bus.a0   = 8'h80;
    step;
    chk("abort.rst_done", {bus.done1, bus.done0}, 2'b00);
    chk("abort.rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    #3;
    rst_n = 1'b1;
    // First edge after release is an arbitration point
    step;
    chk("fresh.gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    bus.req0 = 1'b0;
    step;
    chk("fresh.done", {bus.done1, bus.done0}, 2'b01);
    chk("fresh.result", bus.result, 8'h80);
    chk("fresh.ovf", bus.ovf, 1'b1);
    chk("fresh.c_out", bus.c_out, 1'b0);
    step;
    chk("fresh.idle", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/neg_arbiter.md
NEG_ARBITER -- requirements
Module: neg_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state rising-edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req0, req1  input  1 each  operation request from requester 0 / 1; held until the matching gnt.
REQ-004 SHALL have ports: a0, a1  input  8 each  operands; stable while the matching req is high.
REQ-005 SHALL have ports: gnt0, gnt1  output  1 each  one-cycle pulse, operand captured.
REQ-006 SHALL have ports: done0, done1  output  1 each  one-cycle pulse, result valid for that requester.
REQ-007 SHALL have ports: result  output  8  registered two's-complement negation of the captured operand.
REQ-008 SHALL have ports: c_out  output  1  registered carry out of the negation unit.
REQ-009 SHALL have ports: ovf  output  1  registered flag, captured operand was 8'h80.
REQ-010 SHALL have ports: busy  output  1  high in EXEC and DONE.

Function
REQ-011 SHALL instantiate the existing NEG unit once, with the captured operand register op_q on its input; no second negator.
REQ-012 SHALL implement FSM states IDLE, EXEC and DONE; encoding is free.
REQ-013 IDLE: no req -> stay IDLE; any req -> latch the winner's operand into op_q and the winner index into owner_q, then go to EXEC.
REQ-014 EXEC: gnt<owner_q> SHALL be high for exactly this cycle; req inputs ignored; at the clock edge latch the NEG outputs into result/c_out, set ovf = (op_q == 8'h80), go to DONE.
REQ-015 DONE: done<owner_q> SHALL be high for exactly this cycle; arbitration SHALL be identical to IDLE (a req goes to EXEC, none goes to IDLE).
REQ-016 Latency SHALL be: capture edge -> gnt (1 cycle) -> done (next cycle); back-to-back throughput SHALL be one operation per 2 cycles.
REQ-017 result, c_out and ovf SHALL hold their values until the next EXEC->DONE edge.
REQ-018 c_out SHALL be 1 only for operand 8'h00; result for 8'h80 SHALL be 8'h80 with ovf=1.
REQ-019 gnt0/gnt1 SHALL never be high together; done0/done1 SHALL never be high together.
REQ-020 Simultaneous req0 and req1 SHALL be resolved per REQ-027/REQ-028.
REQ-021 The loser's req SHALL remain pending with no loss; it is served at the next arbitration point.
REQ-022 A req dropped before its gnt SHALL be treated as withdrawn, with no side effect.

Reset
REQ-023 rst_n low SHALL asynchronously force: state=IDLE; gnt0, gnt1, done0, done1, busy, c_out, ovf = 0; result = 8'h00; op_q = 8'h00; owner_q = 0; last_q = 1.
REQ-024 Reset asserted mid-operation (EXEC or DONE) SHALL abort that operation; no done pulse SHALL follow for it.
REQ-025 Release of rst_n SHALL take effect on the first rising clk edge after deassertion; the first arbitration SHALL be on that edge.

Configuration
REQ-026 Macro NEG_ARB_RR_EN SHALL select the arbitration policy at compile time.
REQ-027 With NEG_ARB_RR_EN defined: on a tie, the requester not equal to last_q wins; last_q updates to the winner at each capture.
REQ-028 Without NEG_ARB_RR_EN: req0 SHALL always win a tie; last_q is unused (may be removed).

Verification
REQ-029 Reset, then req0=1, a0=8'h05 -> gnt0 one cycle later, done0 the following cycle, result=8'hFB, c_out=0, ovf=0.
REQ-030 a1=8'h00 via req1 -> result=8'h00, c_out=1, ovf=0; a0=8'h80 -> result=8'h80, ovf=1, c_out=0.
REQ-031 req0 and req1 held continuously with NEG_ARB_RR_EN defined -> grants alternate 0,1,0,1 at a 2-cycle spacing; without the macro -> all grants go to requester 0 while req0 stays high.
REQ-032 rst_n pulsed low during EXEC of an a1=8'h10 operation -> all outputs 0 immediately, no done1; a fresh request after release completes normally.
REQ-033 Lossless tie, RR mode: req0 (a0=8'h01) and req1 (a1=8'h7F) rise in the same cycle -> done0 result 8'hFF, then done1 result 8'h81; gnt/done never overlap.
